// File: rtl/imem_fetch_unit_if.sv
// Fetch/programming bus between the fetch stage and the instruction memory.
// master drives requests and loader data; slave is the memory unit.
interface imem_fetch_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 64
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              flush;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_fault;
    logic              prog_en;
    logic              prog_we;
    logic [DATA_W-1:0] prog_data;
    logic [CNT_W-1:0]  prog_count;
    logic              prog_ovf;

    modport master (
        output fetch_req, fetch_addr, flush, prog_en, prog_we, prog_data,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, prog_count, prog_ovf
    );

    modport slave (
        input  fetch_req, fetch_addr, flush, prog_en, prog_we, prog_data,
        output fetch_ready, fetch_valid, fetch_instr, fetch_fault, prog_count, prog_ovf
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Run-time loadable instruction memory with a fetch handshake, 1- or 2-cycle
// read latency, flush, fault reporting and a sequential loader port.
module imem_fetch_unit #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 64,
    parameter int unsigned       READ_LAT = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input logic              clk,
    input logic              rst_n,
    imem_fetch_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {StRun, StProg} state_e;

    state_e state_q, state_d;

    logic              fetch_ready;
    logic              prog_enter;
    logic              prog_wr;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc_valid;
    logic              acc_fault;
    logic [DATA_W-1:0] acc_instr;
    logic [PTR_W-1:0]  word_idx;

    logic              src_valid;
    logic              src_fault;
    logic [DATA_W-1:0] src_instr;

    logic              valid_q;
    logic              fault_q;
    logic [DATA_W-1:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_ready = 1'b0;
        prog_enter  = 1'b0;
        prog_wr     = 1'b0;
        unique case (state_q)
            StRun: begin
                fetch_ready = !bus.prog_en;
                if (bus.prog_en) begin
                    state_d    = StProg;
                    prog_enter = 1'b1;
                end
            end
            StProg: begin
                prog_wr = bus.prog_we;
                if (!bus.prog_en) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Loader: pointer wraps naturally at DEPTH, count saturates, ovf is sticky.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (prog_enter) begin
            ptr_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (prog_wr) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ovf_d = 1'b1;
            end
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_wr) begin
            mem_q[ptr_q] <= bus.prog_data;
        end
    end

    // Any set bit above the word index means out of range; no aliasing.
    assign word_idx  = bus.fetch_addr[PTR_W+1:2];
    assign acc_valid = bus.fetch_req && fetch_ready;
    assign acc_fault = (|bus.fetch_addr[1:0]) || (|bus.fetch_addr[ADDR_W-1:PTR_W+2]);
    assign acc_instr = acc_fault ? NOP_WORD : mem_q[word_idx];

    if (READ_LAT == 2) begin : g_lat2
        logic              s1_valid_q;
        logic              s1_fault_q;
        logic [DATA_W-1:0] s1_instr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_fault_q <= 1'b0;
                s1_instr_q <= '0;
            end else begin
                s1_valid_q <= acc_valid;
                if (acc_valid) begin
                    s1_fault_q <= acc_fault;
                    s1_instr_q <= acc_instr;
                end
            end
        end

        // Flush kills the older in-flight fetch but not the one accepted with it.
        assign src_valid = s1_valid_q && !bus.flush;
        assign src_fault = s1_fault_q;
        assign src_instr = s1_instr_q;
    end else begin : g_lat1
        assign src_valid = acc_valid;
        assign src_fault = acc_fault;
        assign src_instr = acc_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            instr_q <= '0;
        end else begin
            valid_q <= src_valid;
            if (src_valid) begin
                fault_q <= src_fault;
                instr_q <= src_instr;
            end
        end
    end

    assign bus.fetch_ready = fetch_ready;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_instr = instr_q;
    assign bus.fetch_fault = fault_q;
    assign bus.prog_count  = cnt_q;
    assign bus.prog_ovf    = ovf_q;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: latency-1 and latency-2 instances share stimulus
// and are checked against a queue-based reference model every cycle.
module tb_imem_fetch_unit;
    typedef struct {
        int          due;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] mem_m [64];
    bit          prog_mode = 1'b0;
    int          ptr_m = 0;
    int          cnt_m = 0;
    bit          ovf_m = 1'b0;
    logic [31:0] last_i [2] = '{32'h0, 32'h0};
    logic        last_f [2] = '{1'b0, 1'b0};

    imem_fetch_unit_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) b1 ();
    imem_fetch_unit_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) b2 ();

    imem_fetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .READ_LAT(1),
                      .NOP_WORD(32'h0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    imem_fetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .READ_LAT(2),
                      .NOP_WORD(32'h0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit req, input logic [31:0] addr, input bit fl, input bit pen,
                         input bit pwe, input logic [31:0] pd);
        b1.fetch_req = req; b1.fetch_addr = addr; b1.flush = fl;
        b1.prog_en = pen; b1.prog_we = pwe; b1.prog_data = pd;
        b2.fetch_req = req; b2.fetch_addr = addr; b2.flush = fl;
        b2.prog_en = pen; b2.prog_we = pwe; b2.prog_data = pd;
    endtask

    function automatic exp_t lookup(input logic [31:0] addr, input int due);
        exp_t e;
        e.due = due;
        if (addr[1:0] != 2'b00 || (addr >> 2) >= 64) begin
            e.instr = 32'h0;
            e.fault = 1'b1;
        end else begin
            e.instr = mem_m[addr >> 2];
            e.fault = 1'b0;
        end
        return e;
    endfunction

    task automatic check_out(input int d);
        exp_t        e;
        bit          v = 1'b0;
        logic        o_valid, o_fault;
        logic [31:0] o_instr;
        if (d == 0) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); v = 1'b1; end
            o_valid = b1.fetch_valid; o_fault = b1.fetch_fault; o_instr = b1.fetch_instr;
        end else begin
            if (q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); v = 1'b1; end
            o_valid = b2.fetch_valid; o_fault = b2.fetch_fault; o_instr = b2.fetch_instr;
        end
        if (v) begin
            last_i[d] = e.instr;
            last_f[d] = e.fault;
        end
        chk($sformatf("valid_lat%0d@%0d", d + 1, cyc), {31'h0, o_valid}, {31'h0, v});
        chk($sformatf("instr_lat%0d@%0d", d + 1, cyc), o_instr, last_i[d]);
        chk($sformatf("fault_lat%0d@%0d", d + 1, cyc), {31'h0, o_fault}, {31'h0, last_f[d]});
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic cycle(input bit req, input logic [31:0] addr, input bit fl, input bit pen,
                         input bit pwe, input logic [31:0] pd);
        bit rdy;
        drive(req, addr, fl, pen, pwe, pd);
        @(negedge clk);
        rdy = !prog_mode && !pen;
        chk("ready_lat1", {31'h0, b1.fetch_ready}, {31'h0, rdy});
        chk("ready_lat2", {31'h0, b2.fetch_ready}, {31'h0, rdy});
        check_out(0);
        check_out(1);
        chk("count_lat1", {25'h0, b1.prog_count}, cnt_m);
        chk("count_lat2", {25'h0, b2.prog_count}, cnt_m);
        chk("ovf_lat1", {31'h0, b1.prog_ovf}, {31'h0, ovf_m});
        chk("ovf_lat2", {31'h0, b2.prog_ovf}, {31'h0, ovf_m});
        if (fl) begin
            while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
            while (q2.size() > 0 && q2[$].due > cyc) void'(q2.pop_back());
        end
        if (req && rdy) begin
            q1.push_back(lookup(addr, cyc + 1));
            q2.push_back(lookup(addr, cyc + 2));
        end
        if (prog_mode && pwe) begin
            mem_m[ptr_m] = pd;
            if (ptr_m == 63) ovf_m = 1'b1;
            ptr_m = (ptr_m + 1) % 64;
            if (cnt_m < 64) cnt_m++;
        end
        if (!prog_mode && pen) begin
            prog_mode = 1'b1;
            ptr_m = 0;
            cnt_m = 0;
            ovf_m = 1'b0;
        end else if (prog_mode && !pen) begin
            prog_mode = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic async_reset_pulse();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #2;
        chk("rst_valid_lat1", {31'h0, b1.fetch_valid}, 32'h0);
        chk("rst_valid_lat2", {31'h0, b2.fetch_valid}, 32'h0);
        chk("rst_instr_lat1", b1.fetch_instr, 32'h0);
        chk("rst_instr_lat2", b2.fetch_instr, 32'h0);
        chk("rst_fault_lat1", {31'h0, b1.fetch_fault}, 32'h0);
        chk("rst_fault_lat2", {31'h0, b2.fetch_fault}, 32'h0);
        chk("rst_count_lat1", {25'h0, b1.prog_count}, 32'h0);
        chk("rst_ovf_lat2", {31'h0, b2.prog_ovf}, 32'h0);
        q1.delete();
        q2.delete();
        last_i = '{32'h0, 32'h0};
        last_f = '{1'b0, 1'b0};
        prog_mode = 1'b0;
        ptr_m = 0;
        cnt_m = 0;
        ovf_m = 1'b0;
        rst_n = 1'b1;
        #1;
    endtask

    logic [31:0] prog_words [6] = '{32'h20080008, 32'h20090003, 32'h01095020,
                                    32'h01095822, 32'hac0a0000, 32'hac0b0004};

    initial begin
        bit          pen_cur;
        int          k;
        logic [31:0] a;

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 rst_n = 1'b0;
        #2;
        chk("init_valid", {31'h0, b1.fetch_valid}, 32'h0);
        chk("init_instr", b2.fetch_instr, 32'h0);
        chk("init_count", {25'h0, b1.prog_count}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load six words; the write offered on the prog_en rising cycle is dropped.
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hdeadbeef);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, prog_words[i]);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);

        // Faults: misaligned, first out-of-range index, high address bits set.
        cycle(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'hffff_ff00, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);

        // Flush together with a branch-target fetch, then a bare flush.
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(3);
        cycle(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(3);

        // Interlock: prog_en rises under a request; the prior fetch still completes.
        cycle(1'b1, 32'hc, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h0badf00d);
        for (int i = 0; i < 65; i++) cycle(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'(i));
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'hfc, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);

        // Random traffic with occasional reprogramming bursts.
        pen_cur = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (pen_cur) begin
                if ($urandom_range(0, 9) == 0) pen_cur = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                pen_cur = 1'b1;
            end
            k = int'($urandom_range(0, 9));
            if (k < 7) a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            else if (k == 7) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else if (k == 8) a = 32'($urandom_range(64, 1023)) << 2;
            else a = $urandom;
            cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 9) == 0, pen_cur,
                  $urandom_range(0, 1) == 1, $urandom);
        end
        idle(3);

        // Async reset between accept and result; nothing may emerge afterwards.
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
        async_reset_pulse();
        idle(4);
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised synchronous instruction memory with a fetch handshake, a configurable read latency, fault reporting and a sequential programming (loader) port.
- Sits between the PC/fetch stage and the decode stage of the MIPS core.
- Successor to the fixed 64-word combinational instruction ROM: contents are loaded at run time instead of hard-coded.
- Flush support lets a taken branch discard in-flight fetches.

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 32, byte-address width of fetch_addr.
- DEPTH, 64, number of words; power of two, at least 4.
- READ_LAT, 1, fetch latency in cycles; legal values 1 or 2.
- NOP_WORD, 32'h00000000, word returned on a faulted fetch.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address of the requested instruction.
- fetch_ready  out  1  unit accepts a request this cycle.
- flush  in  1  discard all in-flight fetches.
- fetch_valid  out  1  fetch_instr and fetch_fault are valid (one-cycle pulse per accepted request).
- fetch_instr  out  DATA_W  fetched instruction.
- fetch_fault  out  1  accepted address was misaligned or out of range.
- prog_en  in  1  programming mode request.
- prog_we  in  1  write prog_data at the internal load pointer.
- prog_data  in  DATA_W  word to load.
- prog_count  out  log2(DEPTH)+1  words written since entering PROG, saturating at DEPTH.
- prog_ovf  out  1  sticky flag: a write wrapped past word DEPTH-1.

Behaviour:
- Reset (rst_n=0, async):
  - state=RUN; pipeline valid bits cleared.
  - fetch_valid=0, fetch_instr=0, fetch_fault=0, prog_count=0, prog_ovf=0, load pointer=0.
  - Memory array is not reset.
  - Reset mid-operation drops all in-flight fetches and any partial load; no output pulse follows reset release.
- State machine, two states, both transitions on the clock edge:
  - RUN -> PROG when prog_en=1. On entry: load pointer=0, prog_count=0, prog_ovf=0.
  - PROG -> RUN when prog_en=0.
- fetch_ready = (state==RUN) && !prog_en, combinational.
- Accept: fetch_req && fetch_ready on an edge.
  - fetch_addr and the memory word are captured in the accept cycle (read at stage 1).
  - Results are presented READ_LAT cycles after accept: fetch_valid=1 for exactly one cycle, together with fetch_instr and fetch_fault.
  - One accept per cycle; back-to-back accepts yield back-to-back valid pulses.
  - fetch_instr and fetch_fault hold their last values while fetch_valid=0.
- Word index = fetch_addr[ADDR_W-1:2].
- Fault (fetch_fault=1, fetch_instr=NOP_WORD) when either holds:
  - fetch_addr[1:0] != 0 (misaligned);
  - word index >= DEPTH (out of range); no aliasing.
- Flush:
  - Clears all pipeline valid bits at the edge; no fetch_valid appears for requests accepted before the flush.
  - A request presented in the same cycle as flush is accepted and completes normally (branch target).
- Entering PROG with fetches in flight: they complete normally with the data captured at accept.
- Programming writes, while state==PROG and prog_we=1:
  - mem[pointer] <= prog_data; pointer increments.
  - pointer wraps DEPTH-1 -> 0; on wrap, prog_ovf is set.
  - prog_count increments and saturates at DEPTH.
  - prog_we in RUN, or in the cycle prog_en first rises, is ignored.
- prog_count and prog_ovf hold their values after returning to RUN until the next PROG entry.

Test Plan:
- Load then fetch:
  - Stimulus: PROG; write 20080008, 20090003, 01095020, 01095822, ac0a0000, ac0b0004; RUN; fetch addr 0x0..0x14 back-to-back.
  - Required: prog_count=6, prog_ovf=0; six consecutive fetch_valid pulses returning those words in order, fault=0, first valid READ_LAT cycles after first accept.
- Faults:
  - Stimulus: fetch 0x2 (misaligned), then 0x100 (DEPTH=64, index 64).
  - Required: both fetch_fault=1, fetch_instr=0x00000000.
- Flush:
  - Stimulus: READ_LAT=2; accept 0x0, next cycle flush together with fetch 0x8.
  - Required: exactly one fetch_valid pulse, carrying mem[2]=01095020.
- Overflow:
  - Stimulus: PROG; write 65 words where word k = k.
  - Required: prog_count=64, prog_ovf=1; fetch 0x0 returns 64.
- Mode interlock:
  - Stimulus: assert prog_en while fetch_req=1.
  - Required: fetch_ready=0 that cycle; the in-flight fetch accepted the previous cycle still produces fetch_valid.
- Async reset mid-fetch:
  - Stimulus: pull rst_n low between accept and result.
  - Required: all outputs 0 immediately; no fetch_valid pulse after release.
